// File: rtl/bus_master_port.sv
// Master-side serial port feeding the arbiter's m1_* lane: serializes device select, waits for ack,
// then shifts the address and write data out or read data in. Optional parity via BUS_MASTER_PORT_PARITY_EN.
module bus_master_port #(
    parameter int DEV_W       = 5,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [DEV_W-1:0]  req_dev,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              m_mode,
    output logic              m_wr_bus,
    output logic              m_master_valid,
    input  logic              m_slave_ready,
    output logic              m_master_ready,
    input  logic              m_slave_valid,
    input  logic              m_rd_bus,
    input  logic              m_ack
);

`ifdef BUS_MASTER_PORT_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    localparam int FRAME_W = DATA_W + PAR_W;
    localparam int MAX_A   = (DEV_W > ADDR_W) ? DEV_W : ADDR_W;
    localparam int SH_W    = (MAX_A > FRAME_W) ? MAX_A : FRAME_W;
    localparam int CNT_W   = $clog2(SH_W + 1);
    localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEV_LAST   = CNT_W'(DEV_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEV,
        ACK_WAIT,
        ADDR,
        WDATA,
        RDATA,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SH_W-1:0]    shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               mode_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic [FRAME_W-1:0] rx_sh;
    logic               err_r;
    logic [FRAME_W-1:0] tx_frame;
    logic               parity_bad;
    logic               tx_fire;
    logic               rx_fire;
    logic               last_bit;

    // Write frame optionally carries an even-parity bit over address and data.
`ifdef BUS_MASTER_PORT_PARITY_EN
    assign tx_frame   = {wdata_r, ^{addr_r, wdata_r}};
    assign parity_bad = ^rx_sh;
`else
    assign tx_frame   = wdata_r;
    assign parity_bad = 1'b0;
`endif

    assign tx_fire = m_slave_ready && ((state == DEV) || (state == ADDR) || (state == WDATA));
    assign rx_fire = m_slave_valid && (state == RDATA);

    always_comb begin
        last_bit = 1'b0;
        case (state)
            DEV:           last_bit = (bit_cnt == DEV_LAST);
            ADDR:          last_bit = (bit_cnt == ADDR_LAST);
            WDATA, RDATA:  last_bit = (bit_cnt == FRAME_LAST);
            default:       last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs; everything is forced low while reset is held.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_err        = 1'b0;
        rsp_rdata      = '0;
        m_master_valid = 1'b0;
        m_master_ready = 1'b0;
        m_wr_bus       = 1'b0;
        m_mode         = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = DEV;
            end
            DEV: begin
                m_master_valid = 1'b1;
                if (tx_fire && last_bit) state_next = ACK_WAIT;
            end
            ACK_WAIT: begin
                m_master_ready = 1'b1;
                if (m_slave_valid) state_next = m_ack ? ADDR : DONE;
                else if (to_cnt == TO_LAST) state_next = DONE;
            end
            ADDR: begin
                m_master_valid = 1'b1;
                if (tx_fire && last_bit) state_next = mode_r ? WDATA : RDATA;
            end
            WDATA: begin
                m_master_valid = 1'b1;
                if (tx_fire && last_bit) state_next = DONE;
            end
            RDATA: begin
                m_master_ready = 1'b1;
                if (rx_fire && last_bit) state_next = DONE;
            end
            DONE: begin
                rsp_valid  = 1'b1;
                rsp_err    = err_r | (~mode_r & parity_bad);
                rsp_rdata  = (!mode_r && !rsp_err) ? rx_sh[FRAME_W-1 -: DATA_W] : '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (m_master_valid) m_wr_bus = shift_reg[SH_W-1];
        if (state != IDLE) m_mode = mode_r;
        if (rst) begin
            req_ready      = 1'b0;
            rsp_valid      = 1'b0;
            rsp_err        = 1'b0;
            rsp_rdata      = '0;
            m_master_valid = 1'b0;
            m_master_ready = 1'b0;
            m_wr_bus       = 1'b0;
            m_mode         = 1'b0;
        end
    end

    // Each phase loads its field MSB-aligned so the serial bit is always the register MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            mode_r    <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            rx_sh     <= '0;
            err_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mode_r    <= req_mode;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        shift_reg <= SH_W'(req_dev) << (SH_W - DEV_W);
                        bit_cnt   <= '0;
                        to_cnt    <= '0;
                        rx_sh     <= '0;
                        err_r     <= 1'b0;
                    end
                end
                DEV: begin
                    if (tx_fire) begin
                        shift_reg <= shift_reg << 1;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            to_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
                    if (m_slave_valid) begin
                        if (m_ack) begin
                            shift_reg <= SH_W'(addr_r) << (SH_W - ADDR_W);
                            bit_cnt   <= '0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        err_r <= 1'b1;
                    end
                end
                ADDR: begin
                    if (tx_fire) begin
                        if (last_bit) begin
                            shift_reg <= SH_W'(tx_frame) << (SH_W - FRAME_W);
                            bit_cnt   <= '0;
                        end else begin
                            shift_reg <= shift_reg << 1;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (tx_fire) begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                RDATA: begin
                    if (rx_fire) begin
                        rx_sh   <= {rx_sh[FRAME_W-2:0], m_rd_bus};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed and random transactions against a frame-level reference model
// of the expected serial bit stream and response.
module tb_bus_master_port;

    localparam int DEV_W       = 5;
    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 16;
`ifdef BUS_MASTER_PORT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_mode = 1'b0;
    logic [DEV_W-1:0]  req_dev = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              m_mode;
    logic              m_wr_bus;
    logic              m_master_valid;
    logic              m_slave_ready = 1'b0;
    logic              m_master_ready;
    logic              m_slave_valid = 1'b0;
    logic              m_rd_bus = 1'b0;
    logic              m_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_master_port #(
        .DEV_W(DEV_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_dev(req_dev), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_mode(m_mode), .m_wr_bus(m_wr_bus), .m_master_valid(m_master_valid),
        .m_slave_ready(m_slave_ready), .m_master_ready(m_master_ready),
        .m_slave_valid(m_slave_valid), .m_rd_bus(m_rd_bus), .m_ack(m_ack)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ack_kind: 0 ack, 1 nack, 2 silent (timeout). stall: 0 none, 1 toggle, 2 random.
    // abort_bits >= 0 asserts reset once that many data bits have been shifted.
    task automatic applyStimulus(input string tag, input logic mode, input logic [DEV_W-1:0] dev,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                 input logic [DATA_W-1:0] rdata, input logic rpar_flip,
                                 input int ack_kind, input int ack_delay, input int stall,
                                 input int abort_bits);
        logic [63:0]       exp_vec, act_vec;
        int                exp_len, act_len, rd_idx, waited, cycles, exp_lat;
        int                mode_err, mv_err, stable_err;
        logic [DATA_W:0]   rd_frame;
        logic              ack_done, done, prev_stalled, prev_bit, tog, got_err, exp_err;
        logic [DATA_W-1:0] got_rdata, exp_rdata;

        exp_vec = '0; act_vec = '0; exp_len = 0; act_len = 0;
        rd_idx = 0; waited = 0; cycles = 0; mode_err = 0; mv_err = 0; stable_err = 0;
        ack_done = 1'b0; done = 1'b0; prev_stalled = 1'b0; prev_bit = 1'b0; tog = 1'b0;
        got_err = 1'b0; got_rdata = '0;

        for (int i = DEV_W - 1; i >= 0; i--) begin
            exp_vec = {exp_vec[62:0], dev[i]}; exp_len++;
        end
        if (ack_kind == 0) begin
            for (int i = ADDR_W - 1; i >= 0; i--) begin
                exp_vec = {exp_vec[62:0], addr[i]}; exp_len++;
            end
            if (mode) begin
                for (int i = DATA_W - 1; i >= 0; i--) begin
                    exp_vec = {exp_vec[62:0], wdata[i]}; exp_len++;
                end
                if (PAR == 1) begin
                    exp_vec = {exp_vec[62:0], ^{addr, wdata}}; exp_len++;
                end
            end
        end
        exp_err   = (ack_kind != 0) || (!mode && (PAR == 1) && rpar_flip);
        exp_rdata = (!mode && !exp_err) ? rdata : '0;
        rd_frame  = {rdata, (^rdata) ^ rpar_flip};
        exp_lat   = DEV_W + ((ack_kind == 2) ? ACK_TIMEOUT : ack_delay + 1)
                  + ((ack_kind == 0) ? ADDR_W + DATA_W + PAR : 0) + 1;

        @(negedge clk); #1;
        checkOutput({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_mode = mode; req_dev = dev; req_addr = addr; req_wdata = wdata;

        while (!done && cycles < 400) begin
            @(negedge clk); #1;
            cycles++;
            req_valid = 1'b0;
            req_mode  = 1'($urandom);
            req_dev   = DEV_W'($urandom);
            req_addr  = ADDR_W'($urandom);
            req_wdata = DATA_W'($urandom);
            m_slave_ready = 1'b0; m_slave_valid = 1'b0; m_ack = 1'b0; m_rd_bus = 1'b0;
            if (m_mode !== mode) mode_err++;
            if (prev_stalled && (m_wr_bus !== prev_bit)) stable_err++;
            prev_stalled = 1'b0;
            if (rsp_valid === 1'b1) begin
                done = 1'b1; got_err = rsp_err; got_rdata = rsp_rdata;
            end else if (abort_bits >= 0 && act_len == DEV_W + ADDR_W + abort_bits) begin
                rst = 1'b1;
                @(negedge clk); #1;
                checkOutput({tag, ".rst_outputs"},
                            64'({req_ready, rsp_valid, m_mode, m_wr_bus, m_master_valid, m_master_ready}),
                            64'd0);
                rst = 1'b0;
                #1;
                checkOutput({tag, ".ready_after_rst"}, 64'({req_ready, rsp_valid}), 64'b10);
                checkOutput({tag, ".bits_before_rst"}, act_vec, exp_vec >> (exp_len - act_len));
                return;
            end else begin
                tog = ~tog;
                if (m_master_valid === 1'b1) begin
                    m_slave_ready = (stall == 0) ? 1'b1 : (stall == 1) ? tog : 1'($urandom);
                    if (m_slave_ready) begin
                        act_vec = {act_vec[62:0], m_wr_bus}; act_len++;
                    end else begin
                        prev_stalled = 1'b1; prev_bit = m_wr_bus;
                    end
                end
                if (m_master_ready === 1'b1) begin
                    if (!ack_done) begin
                        if (ack_kind != 2 && waited == ack_delay) begin
                            m_slave_valid = 1'b1; m_ack = (ack_kind == 0); ack_done = 1'b1;
                        end else begin
                            waited++;
                        end
                    end else begin
                        if (m_master_valid !== 1'b0) mv_err++;
                        m_slave_valid = (stall == 0) ? 1'b1 : (stall == 1) ? tog : 1'($urandom);
                        if (m_slave_valid && rd_idx <= DATA_W) begin
                            m_rd_bus = rd_frame[DATA_W - rd_idx]; rd_idx++;
                        end
                    end
                end
            end
        end

        checkOutput({tag, ".rsp_seen"}, 64'(done), 64'd1);
        checkOutput({tag, ".rsp_err"}, 64'(got_err), 64'(exp_err));
        checkOutput({tag, ".rsp_rdata"}, 64'(got_rdata), 64'(exp_rdata));
        checkOutput({tag, ".bit_count"}, 64'(act_len), 64'(exp_len));
        checkOutput({tag, ".bits"}, act_vec, exp_vec);
        checkOutput({tag, ".mode_held"}, 64'(mode_err), 64'd0);
        checkOutput({tag, ".no_mv_in_rdata"}, 64'(mv_err), 64'd0);
        checkOutput({tag, ".wr_bus_stable"}, 64'(stable_err), 64'd0);
        if (stall == 0) checkOutput({tag, ".latency"}, 64'(cycles), 64'(exp_lat));
        @(negedge clk); #1;
        checkOutput({tag, ".after_done"}, 64'({rsp_valid, req_ready, m_mode, m_master_valid}), 64'b0100);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic              r_mode;
        logic [DEV_W-1:0]  r_dev;
        logic [ADDR_W-1:0] r_addr;
        logic [DATA_W-1:0] r_wdata, r_rdata;
        int                r_kind;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    64'({req_ready, rsp_valid, rsp_err, rsp_rdata, m_mode, m_wr_bus, m_master_valid, m_master_ready}),
                    64'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset_release_ready", 64'(req_ready), 64'd1);

        applyStimulus("wr_basic", 1'b1, 5'b00001, 12'hA5C, 8'h3C, 8'h00, 1'b0, 0, 2, 0, -1);
        applyStimulus("rd_basic", 1'b0, 5'b00010, 12'h001, 8'h00, 8'hB1, 1'b0, 0, 1, 0, -1);
        applyStimulus("wr_stall", 1'b1, 5'b00001, 12'hA5C, 8'h3C, 8'h00, 1'b0, 0, 2, 1, -1);
        applyStimulus("rd_stall", 1'b0, 5'b10110, 12'hF0F, 8'h00, 8'h5A, 1'b0, 0, 0, 1, -1);
        applyStimulus("nack",     1'b0, 5'b00011, 12'h123, 8'h00, 8'hFF, 1'b0, 1, 1, 0, -1);
        applyStimulus("timeout",  1'b1, 5'b11111, 12'hFFF, 8'hAA, 8'h00, 1'b0, 2, 0, 0, -1);
        applyStimulus("rst_mid",  1'b1, 5'b01010, 12'h3C3, 8'hC5, 8'h00, 1'b0, 0, 0, 0, 3);
        applyStimulus("after_rst", 1'b1, 5'b00100, 12'h800, 8'h81, 8'h00, 1'b0, 0, 0, 0, -1);
        if (PAR == 1) begin
            applyStimulus("par_bad",  1'b0, 5'b00010, 12'h010, 8'h00, 8'h07, 1'b1, 0, 0, 0, -1);
            applyStimulus("par_good", 1'b0, 5'b00010, 12'h010, 8'h00, 8'h07, 1'b0, 0, 0, 0, -1);
        end

        for (int n = 0; n < 24; n++) begin
            r_mode  = 1'($urandom);
            r_dev   = DEV_W'($urandom);
            r_addr  = ADDR_W'($urandom);
            r_wdata = DATA_W'($urandom);
            r_rdata = DATA_W'($urandom);
            r_kind  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            applyStimulus("random", r_mode, r_dev, r_addr, r_wdata, r_rdata,
                          (PAR == 1) ? 1'($urandom) : 1'b0, r_kind,
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
